// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard detection for a 5-stage pipeline: tracks EX/MEM/WB destination
// shadows, registers EX operand-forward selects, and raises load-use and multi-cycle-load stalls.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_id,
    output logic              stall_mem
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } slot_t;

    localparam logic [1:0] LOAD_CNT = 2'(LOAD_LAT - 1);

    slot_t      ex_slot;
    slot_t      mem_slot;
    // WB shadow is kept for completeness of the pipeline picture; no decision reads it.
    slot_t      wb_slot_unused;
    slot_t      id_slot;
    logic [1:0] lat_cnt;
    logic       ex_src;
    logic       mem_src;
    logic       bubble;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    function automatic logic is_source(slot_t s);
        return s.valid & s.reg_write & (s.rd != '0);
    endfunction

    always_comb begin
        stall_mem = (lat_cnt != 2'd0);
        ex_src    = is_source(ex_slot);
        mem_src   = is_source(mem_slot);
        stall_id  = !stall_mem & id_valid & ex_src & ex_slot.mem_read &
                    ((id_rs == ex_slot.rd) | (id_uses_rt & (id_rt == ex_slot.rd)));
        bubble    = stall_id | flush | !id_valid;

        id_slot           = '0;
        id_slot.valid     = 1'b1;
        id_slot.rd        = id_rd;
        id_slot.reg_write = id_reg_write;
        id_slot.mem_read  = id_mem_read;

        fwd_a_next = 2'b00;
        if (!bubble) begin
            if (ex_src && ex_slot.rd == id_rs)
                fwd_a_next = 2'b10;
            else if (mem_src && mem_slot.rd == id_rs)
                fwd_a_next = 2'b01;
        end

        fwd_b_next = 2'b00;
        if (!bubble && id_uses_rt) begin
            if (ex_src && ex_slot.rd == id_rt)
                fwd_b_next = 2'b10;
            else if (mem_src && mem_slot.rd == id_rt)
                fwd_b_next = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot        <= '0;
            mem_slot       <= '0;
            wb_slot_unused <= '0;
            lat_cnt        <= 2'd0;
            fwd_a          <= 2'b00;
            fwd_b          <= 2'b00;
        end else if (stall_mem) begin
            lat_cnt <= lat_cnt - 2'd1;
        end else begin
            ex_slot        <= bubble ? '0 : id_slot;
            mem_slot       <= ex_slot;
            wb_slot_unused <= mem_slot;
            fwd_a          <= fwd_a_next;
            fwd_b          <= fwd_b_next;
            // Counter is zero whenever we get here, so a load entering MEM simply arms it.
            if (ex_slot.valid && ex_slot.mem_read)
                lat_cnt <= LOAD_CNT;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus and are
// each checked against an instruction-level pipeline model.
module tb_fwd_hazard_unit;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_uses_rt, id_reg_write, id_mem_read, flush;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [1:0][1:0] fa, fb;
    logic [1:0]      sid, smem;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(AW), .LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a(fa[0]), .fwd_b(fb[0]),
        .stall_id(sid[0]), .stall_mem(smem[0])
    );

    fwd_hazard_unit #(.REG_AW(AW), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a(fa[1]), .fwd_b(fb[1]),
        .stall_id(sid[1]), .stall_mem(smem[1])
    );

    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    // pipe[k][0] = instruction in EX, [1] = MEM, [2] = WB
    instr_t     pipe [2][3];
    int         wait_left [2];
    logic [1:0] m_fa [2];
    logic [1:0] m_fb [2];
    logic       last_sid [2];
    logic       last_smem [2];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input int k, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d]: got %b expected %b", tag, k, obs, exp);
        end
    endtask

    function automatic bit writes_reg(instr_t s, int r);
        return s.valid && s.wr && s.rd != 0 && s.rd == r;
    endfunction

    function automatic logic [1:0] pick(int k, int r);
        if (writes_reg(pipe[k][0], r)) return 2'b10;
        if (writes_reg(pipe[k][1], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_smem(int k);
        return wait_left[k] > 0;
    endfunction

    function automatic bit exp_sid(int k);
        if (exp_smem(k) || !id_valid || !pipe[k][0].ld) return 1'b0;
        return writes_reg(pipe[k][0], int'(id_rs)) ||
               (id_uses_rt && writes_reg(pipe[k][0], int'(id_rt)));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) pipe[k][i] = '{1'b0, 0, 1'b0, 1'b0};
            wait_left[k] = 0;
            m_fa[k] = 2'b00;
            m_fb[k] = 2'b00;
        end
    endtask

    task automatic model_edge(input int k);
        bit take;
        if (exp_smem(k)) begin
            wait_left[k]--;
            return;
        end
        take = id_valid && !flush && !exp_sid(k);
        m_fa[k] = take ? pick(k, int'(id_rs)) : 2'b00;
        m_fb[k] = (take && id_uses_rt) ? pick(k, int'(id_rt)) : 2'b00;
        if (pipe[k][0].valid && pipe[k][0].ld) wait_left[k] = (k == 0 ? 1 : 3) - 1;
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        if (take) pipe[k][0] = '{1'b1, int'(id_rd), id_reg_write, id_mem_read};
        else      pipe[k][0] = '{1'b0, 0, 1'b0, 1'b0};
    endtask

    // One clock of stimulus, starting and ending at a falling edge.
    task automatic cycle(input bit v, input int rs, input int rt, input bit ut,
                         input int rd, input bit wr, input bit ld, input bit fl);
        id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_uses_rt = ut;
        id_rd = AW'(rd); id_reg_write = wr; id_mem_read = ld; flush = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            last_sid[k]  = sid[k];
            last_smem[k] = smem[k];
            check("stall_id", k, {1'b0, sid[k]}, {1'b0, exp_sid(k)});
            check("stall_mem", k, {1'b0, smem[k]}, {1'b0, exp_smem(k)});
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("fwd_a", k, fa[k], m_fa[k]);
            check("fwd_b", k, fb[k], m_fb[k]);
        end
    endtask

    task automatic alu(input int rs, input int rt, input int rd);
        cycle(1'b1, rs, rt, 1'b1, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load(input int rs, input int rd);
        cycle(1'b1, rs, 0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_fa"}, k, fa[k], 2'b00);
            check({tag, "_fb"}, k, fb[k], 2'b00);
            check({tag, "_sid"}, k, {1'b0, sid[k]}, 2'b00);
            check({tag, "_smem"}, k, {1'b0, smem[k]}, 2'b00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // back-to-back ALU dependency
        alu(1, 2, 3);
        alu(3, 5, 4);
        check("req24_fa", 0, fa[0], 2'b10);
        check("req24_fb", 0, fb[0], 2'b00);
        check("req24_sid", 0, {1'b0, last_sid[0]}, 2'b00);
        idle(4);

        // one-apart dependency on rt
        alu(1, 2, 3);
        alu(8, 9, 10);
        alu(11, 3, 12);
        check("req25_fa", 0, fa[0], 2'b00);
        check("req25_fb", 0, fb[0], 2'b01);
        idle(4);

        // load-use with single-cycle MEM
        load(1, 2);
        alu(2, 2, 6);
        check("req26_sid", 0, {1'b0, last_sid[0]}, 2'b01);
        check("req26_bubble", 0, fa[0], 2'b00);
        alu(2, 2, 6);
        check("req26_sid_off", 0, {1'b0, last_sid[0]}, 2'b00);
        check("req26_fa", 0, fa[0], 2'b01);
        check("req26_fb", 0, fb[0], 2'b01);
        idle(5);

        // multi-cycle load on the LOAD_LAT=3 instance
        load(1, 2);
        alu(2, 9, 6);
        check("req27_sid", 1, {1'b0, last_sid[1]}, 2'b01);
        alu(2, 9, 6);
        check("req27_smem1", 1, {1'b0, last_smem[1]}, 2'b01);
        check("req27_frozen", 1, fa[1], 2'b00);
        alu(2, 9, 6);
        check("req27_smem2", 1, {1'b0, last_smem[1]}, 2'b01);
        alu(2, 9, 6);
        check("req27_smem_off", 1, {1'b0, last_smem[1]}, 2'b00);
        check("req27_fa", 1, fa[1], 2'b01);
        check("lat1_never_smem", 0, {1'b0, smem[0]}, 2'b00);
        idle(5);

        // r0 never forwards or stalls; newest producer wins on double match
        alu(1, 2, 0);
        alu(0, 0, 4);
        check("req28_r0_fa", 0, fa[0], 2'b00);
        check("req28_r0_fb", 0, fb[0], 2'b00);
        idle(4);
        load(1, 0);
        alu(0, 0, 4);
        check("req28_r0_sid", 0, {1'b0, last_sid[0]}, 2'b00);
        idle(5);
        alu(1, 2, 7);
        alu(3, 4, 7);
        alu(7, 7, 8);
        check("req28_dbl_fa", 0, fa[0], 2'b10);
        check("req28_dbl_fb", 0, fb[0], 2'b10);
        idle(5);

        // flush squashes the ID instruction even alongside a load-use stall
        load(1, 2);
        cycle(1'b1, 2, 0, 1'b0, 9, 1'b1, 1'b0, 1'b1);
        alu(9, 9, 10);
        check("flush_untracked", 0, fa[0], 2'b00);
        idle(5);

        // asynchronous reset in the middle of a multi-cycle load stall
        load(1, 5);
        idle(1);
        id_valid = 1'b0;
        #1;
        check("req29_pre_smem", 1, {1'b0, smem[1]}, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("req29_async");
        model_reset();
        @(negedge clk);
        check_all_zero("req29_held");
        rst_n = 1'b1;
        alu(5, 5, 3);
        check("req29_no_spurious", 1, fa[1], 2'b00);
        alu(3, 5, 4);
        check("req29_refill", 1, fa[1], 2'b10);
        idle(5);

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 7) != 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL expose parameter REG_AW, default 5, meaning register-address width in bits.
REQ-002 The block SHALL expose parameter LOAD_LAT, default 1, legal 1..4, meaning cycles a load occupies the MEM stage.
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-004 Ports SHALL be:
  clk           in   1       rising-edge clock
  rst_n         in   1       async active-low reset
  id_valid      in   1       ID-stage instruction present
  id_rs         in   REG_AW  ID source A register
  id_rt         in   REG_AW  ID source B register
  id_uses_rt    in   1       ID instruction reads id_rt
  id_rd         in   REG_AW  ID destination register
  id_reg_write  in   1       ID instruction writes id_rd
  id_mem_read   in   1       ID instruction is a load
  flush         in   1       squash the ID instruction (branch taken)
  fwd_a         out  2       EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
  fwd_b         out  2       EX operand B select, same encoding
  stall_id      out  1       hold PC and IF/ID, insert bubble into EX
  stall_mem     out  1       hold the entire pipeline (multi-cycle load)

Function
REQ-005 The block SHALL keep shadow slots EX, MEM and WB, each holding {valid, rd, reg_write, mem_read}.
REQ-006 A slot SHALL count as a forwarding source only when valid=1, reg_write=1 and rd != 0.
REQ-007 Every edge with stall_mem=0 SHALL shift the slots: ID->EX, EX->MEM, MEM->WB; the old WB contents are discarded.
REQ-008 EX SHALL load a bubble (valid=0) when stall_id=1, flush=1 or id_valid=0; otherwise it loads the ID fields.
REQ-009 stall_id SHALL be combinational and equal to: !stall_mem & id_valid & EX is a source & EX.mem_read & (id_rs==EX.rd | (id_uses_rt & id_rt==EX.rd)).
REQ-010 fwd_a and fwd_b SHALL be registered and updated on the same edge as the EX slot.
REQ-011 fwd_a next value: 10 if EX is a source and EX.rd==id_rs; else 01 if MEM is a source and MEM.rd==id_rs; else 00.
REQ-012 fwd_b next value: the same rule applied to id_rt, forced to 00 when id_uses_rt=0.
REQ-013 The newer producer (10) SHALL win when both slots match; A and B SHALL be resolved independently, and both may be non-zero in the same cycle.
REQ-014 When EX loads a bubble, fwd_a and fwd_b SHALL load 00.
REQ-015 A 2-bit latency counter SHALL load LOAD_LAT-1 on the edge where a valid load enters MEM, then decrement once per cycle down to 0.
REQ-016 stall_mem SHALL be combinational and equal to (counter != 0).
REQ-017 With LOAD_LAT=1, stall_mem SHALL never assert.
REQ-018 While stall_mem=1, all slots, fwd_a, fwd_b and the counter-load logic SHALL hold, except the counter decrement; flush SHALL be ignored.
REQ-019 While stall_mem=1, stall_id SHALL read 0; stall_mem dominates.
REQ-020 flush together with stall_id (stall_mem=0) SHALL produce one bubble; the flushed instruction is never tracked.
REQ-021 Register 0 SHALL never produce a forward or a stall.

Reset
REQ-022 While rst_n=0, all slot valid bits, the counter, fwd_a and fwd_b SHALL be 0; consequently stall_id=0 and stall_mem=0.
REQ-023 Reset SHALL take effect immediately and asynchronously, even mid-stall; release takes effect at the first clk edge with rst_n=1.

Verification
REQ-024 Dependent ALU ops: add r3 then sub r4,r3,r5 back-to-back -> sub in EX with fwd_a=10, fwd_b=00, no stall.
REQ-025 One-apart dependency: r3 producer, unrelated op, then consumer reading rt=r3 -> consumer in EX with fwd_b=01.
REQ-026 Load-use, LOAD_LAT=1: lw r2 followed by add r6,r2,r2 -> stall_id=1 for exactly 1 cycle, EX bubble, then add in EX with fwd_a=fwd_b=01.
REQ-027 LOAD_LAT=3: lw in MEM -> stall_mem=1 for 2 cycles, slots and fwd frozen; a younger dependent op then forwards 01.
REQ-028 Writes to r0 plus double match (EX and MEM both write r7, consumer reads r7) -> r0 gives 00 with no stall; r7 gives 10.
REQ-029 rst_n pulsed low during stall_mem=1 -> outputs 0 within the same cycle; after release, pipeline refills with no spurious forward.
